// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the round-robin memory bus arbiter.
// Imported by the arbiter top level and its priority picker.
package mem_bus_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_e;

    localparam int DEF_NUM_MASTERS = 4;
    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_DATA_W      = 32;

    // Smallest width that can index n entries; never below 1 bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping around.
// Uses a double-width copy of the request vector so the wrap needs no second search.
module rr_priority_picker
    import mem_bus_pkg::*;
#(
    parameter int N  = DEF_NUM_MASTERS,
    parameter int PW = clog2(DEF_NUM_MASTERS)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx
);

    logic [2*N-1:0] dblReq;
    logic [2*N-1:0] mask;
    logic [2*N-1:0] masked;
    logic           found;

    // Bits below ptr in the lower copy are masked; the upper copy supplies the wrapped candidates.
    always_comb begin
        dblReq    = {req, req};
        mask      = ~(({{(2*N-1){1'b0}}, 1'b1} << ptr) - {{(2*N-1){1'b0}}, 1'b1});
        masked    = dblReq & mask;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < 2*N; i++) begin
            if (!found && masked[i]) begin
                found     = 1'b1;
                grant_idx = PW'(i % N);
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory slave port between NUM_MASTERS requesters.
// One outstanding transaction; the winner's fields are latched for the whole slave access.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            m_req,
    input  logic [NUM_MASTERS-1:0]            m_we,
    input  logic [NUM_MASTERS*ADDR_W-1:0]     m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0]     m_wdata,
    input  logic [NUM_MASTERS*(DATA_W/8)-1:0] m_be,
    output logic [NUM_MASTERS-1:0]            m_ready,
    output logic [DATA_W-1:0]                 m_rdata,
    output logic                              s_req,
    output logic                              s_we,
    output logic [ADDR_W-1:0]                 s_addr,
    output logic [DATA_W-1:0]                 s_wdata,
    output logic [DATA_W/8-1:0]               s_be,
    input  logic                              s_ack,
    input  logic [DATA_W-1:0]                 s_rdata
);

    localparam int PW   = clog2(NUM_MASTERS);
    localparam int BE_W = DATA_W / 8;

    arb_state_e             state_q;
    logic [PW-1:0]          ptr_q;
    logic [PW-1:0]          ptr_d;
    logic [PW-1:0]          idx_q;
    logic [NUM_MASTERS-1:0] grant_q;
    logic                   req_q;
    logic                   we_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [DATA_W-1:0]      wdata_q;
    logic [BE_W-1:0]        be_q;

    logic [NUM_MASTERS-1:0] pickGrant;
    logic [PW-1:0]          pickIdx;
    logic [ADDR_W-1:0]      selAddr;
    logic [DATA_W-1:0]      selWdata;
    logic [BE_W-1:0]        selBe;

    rr_priority_picker #(
        .N  (NUM_MASTERS),
        .PW (PW)
    ) uPicker (
        .req       (m_req),
        .ptr       (ptr_q),
        .grant     (pickGrant),
        .grant_idx (pickIdx)
    );

    assign selAddr  = m_addr [int'(pickIdx)*ADDR_W +: ADDR_W];
    assign selWdata = m_wdata[int'(pickIdx)*DATA_W +: DATA_W];
    assign selBe    = m_be   [int'(pickIdx)*BE_W   +: BE_W];

    // The completed master drops to lowest priority next time round.
    assign ptr_d = (idx_q == PW'(NUM_MASTERS - 1)) ? '0 : idx_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            grant_q <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (|m_req) begin
                        grant_q <= pickGrant;
                        idx_q   <= pickIdx;
                        we_q    <= m_we[pickIdx];
                        addr_q  <= selAddr;
                        wdata_q <= selWdata;
                        be_q    <= selBe;
                        req_q   <= 1'b1;
                        state_q <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (s_ack) begin
                        ptr_q   <= ptr_d;
                        req_q   <= 1'b0;
                        state_q <= ARB_IDLE;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign s_req   = req_q;
    assign s_we    = we_q;
    assign s_addr  = addr_q;
    assign s_wdata = wdata_q;
    assign s_be    = be_q;

    // Acks seen outside BUSY are spurious and never reach a master.
    assign m_ready = (state_q == ARB_BUSY && s_ack) ? grant_q : '0;
    assign m_rdata = s_rdata;

endmodule
